if_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Owns the PC and selects the next PC from the ID-stage controller's PC_src: PC+4, EX-resolved branch, j/jal target, or jr/jalr target.
- Handles load-use stalls and control-hazard flushes.
- Drives ID_instruction into the ID-stage controller and ID_pc_plus4 into ID/EX.

---
 rtl/if_stage.sv | 95 +++++++++
 tb/tb_if_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline.
// Optional macro DELAY_SLOT_EN: j/jr/jalr keep the fetched delay-slot instruction instead of flushing.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PC_src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jr_target,
  input  logic        load_use_stall,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] ID_instruction,
  output logic [31:0] ID_pc_plus4,
  output logic        ID_valid
);

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_J   = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pp4_q, pp4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic        unused_low_bits;

  assign pc_plus4    = pc_q + 32'd4;
  assign jump_target = {pp4_q[31:28], instr_q[25:0], 2'b00};
  // Targets are word-aligned by construction; the low bits are intentionally dropped.
  assign unused_low_bits = ^{branch_target[1:0], jr_target[1:0]};

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pp4_d   = pp4_q;
    valid_d = valid_q;
    if (PC_src == PC_BR) begin
      // A taken branch wins over a stall: the stalled ID instruction is wrong-path.
      pc_d    = {branch_target[31:2], 2'b00};
      instr_d = NOP_INSTR;
      pp4_d   = '0;
      valid_d = 1'b0;
    end else if (!load_use_stall) begin
      case (PC_src)
        PC_J, PC_JR: begin
          pc_d = (PC_src == PC_J) ? jump_target : {jr_target[31:2], 2'b00};
`ifdef DELAY_SLOT_EN
          instr_d = imem_rdata;
          pp4_d   = pc_plus4;
          valid_d = 1'b1;
`else
          instr_d = NOP_INSTR;
          pp4_d   = '0;
          valid_d = 1'b0;
`endif
        end
        default: begin
          pc_d    = pc_plus4;
          instr_d = imem_rdata;
          pp4_d   = pc_plus4;
          valid_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pp4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pp4_q   <= pp4_d;
      valid_q <= valid_d;
    end
  end

  assign pc             = pc_q;
  assign imem_addr      = pc_q;
  assign ID_instruction = instr_q;
  assign ID_pc_plus4    = pp4_q;
  assign ID_valid       = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table for the fetch/redirect/stall corners,
// then randomized traffic checked against an arithmetic reference model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  PC_src;
  logic [31:0] branch_target, jr_target;
  logic        load_use_stall;
  logic [31:0] imem_rdata, imem_addr, pc, ID_instruction, ID_pc_plus4;
  logic        ID_valid;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
    .clk(clk), .reset(reset), .PC_src(PC_src), .branch_target(branch_target),
    .jr_target(jr_target), .load_use_stall(load_use_stall), .imem_rdata(imem_rdata),
    .imem_addr(imem_addr), .pc(pc), .ID_instruction(ID_instruction),
    .ID_pc_plus4(ID_pc_plus4), .ID_valid(ID_valid)
  );

  // Instruction memory: address 4 holds "j 0x100"; everything else is a tagged filler word.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h0800_0040;
    return 32'hA500_0000 | (a & 32'h00FF_FFFF);
  endfunction

  assign imem_rdata = imem_word(imem_addr);

  typedef struct {
    bit          rst;
    logic [1:0]  src;
    logic [31:0] bt;
    logic [31:0] jt;
    bit          stall;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pp4;
    bit          e_valid;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input logic [1:0] src, input logic [31:0] bt,
                     input logic [31:0] jt, input bit stall, input logic [31:0] e_pc,
                     input logic [31:0] e_instr, input logic [31:0] e_pp4, input bit e_valid);
    vec_t v;
    v.rst = rst; v.src = src; v.bt = bt; v.jt = jt; v.stall = stall;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_pp4 = e_pp4; v.e_valid = e_valid;
    vecs.push_back(v);
  endtask

  task automatic check32(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, got, exp);
    end
  endtask

  task automatic apply(input bit rst, input logic [1:0] src, input logic [31:0] bt,
                       input logic [31:0] jt, input bit stall);
    reset = rst; PC_src = src; branch_target = bt; jr_target = jt; load_use_stall = stall;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int idx, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pp4, input bit e_valid);
    check32("pc", idx, pc, e_pc);
    check32("imem_addr", idx, imem_addr, e_pc);
    check32("ID_instruction", idx, ID_instruction, e_instr);
    check32("ID_pc_plus4", idx, ID_pc_plus4, e_pp4);
    check32("ID_valid", idx, {31'b0, ID_valid}, {31'b0, e_valid});
  endtask

  // Reference model state: what the architecture says pc and IF/ID should hold.
  longint unsigned m_pc, m_instr, m_pp4;
  bit              m_valid;

  function automatic longint unsigned align4(input longint unsigned x);
    return (x / 4) * 4;
  endfunction

  task automatic model_step(input bit rst, input logic [1:0] src, input logic [31:0] bt,
                            input logic [31:0] jt, input bit stall);
    longint unsigned next4, fetched, tgt;
    next4   = (m_pc + 4) % 64'h1_0000_0000;
    fetched = imem_word(m_pc[31:0]);
    if (rst) begin
      m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0;
    end else if (src == 2'd1) begin
      m_pc = align4(bt); m_instr = 0; m_pp4 = 0; m_valid = 0;
    end else if (stall) begin
      // everything holds
    end else if (src == 2'd0) begin
      m_pc = next4; m_instr = fetched; m_pp4 = next4; m_valid = 1;
    end else begin
      if (src == 2'd2)
        tgt = (m_pp4 / 64'h1000_0000) * 64'h1000_0000 + (m_instr % 64'h400_0000) * 4;
      else
        tgt = align4(jt);
      if (DS) begin m_instr = fetched; m_pp4 = next4; m_valid = 1; end
      else    begin m_instr = 0;       m_pp4 = 0;     m_valid = 0; end
      m_pc = tgt;
    end
  endtask

  initial begin
    reset = 1'b1; PC_src = 2'b00; branch_target = '0; jr_target = '0; load_use_stall = 1'b0;

    // reset, then sequential fetch 0,4,8,C,10
    add(1, 0, 0, 0, 0, 32'h0,  32'h0,         32'h0,  0);
    add(0, 0, 0, 0, 0, 32'h4,  imem_word(0),  32'h4,  1);
    add(0, 0, 0, 0, 0, 32'h8,  32'h0800_0040, 32'h8,  1);
    add(0, 0, 0, 0, 0, 32'hC,  imem_word(8),  32'hC,  1);
    add(0, 0, 0, 0, 0, 32'h10, imem_word(12), 32'h10, 1);
    // j 0x100 sitting in ID with ID_pc_plus4 = 8
    add(1, 0, 0, 0, 0, 32'h0,  32'h0,         32'h0,  0);
    add(0, 0, 0, 0, 0, 32'h4,  imem_word(0),  32'h4,  1);
    add(0, 0, 0, 0, 0, 32'h8,  32'h0800_0040, 32'h8,  1);
    add(0, 2, 0, 0, 0, 32'h100, DS ? imem_word(8) : 32'h0, DS ? 32'hC : 32'h0, DS);
    add(0, 0, 0, 0, 0, 32'h104, imem_word(32'h100), 32'h104, 1);
    add(0, 0, 0, 0, 0, 32'h108, imem_word(32'h104), 32'h108, 1);
    // jr to 0xF lands on 0xC (low bits dropped), then fetch to pc=0x10
    add(0, 3, 0, 32'hF, 0, 32'hC, DS ? imem_word(32'h108) : 32'h0, DS ? 32'h10C : 32'h0, DS);
    add(0, 0, 0, 0, 0, 32'h10, imem_word(12), 32'h10, 1);
    // two-cycle stall at pc=0x10; a jump request during the stall is ignored
    add(0, 0, 0, 0, 1, 32'h10, imem_word(12), 32'h10, 1);
    add(0, 2, 0, 0, 1, 32'h10, imem_word(12), 32'h10, 1);
    add(0, 0, 0, 0, 0, 32'h14, imem_word(16), 32'h14, 1);
    // taken branch overrides stall; target low bits forced
    add(0, 1, 32'h203, 0, 1, 32'h200, 32'h0, 32'h0, 0);
    // jr to top of memory then wrap
    add(0, 3, 0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, DS ? imem_word(32'h200) : 32'h0,
        DS ? 32'h204 : 32'h0, DS);
    add(0, 0, 0, 0, 0, 32'h0, imem_word(32'hFFFF_FFFC), 32'h0, 1);
    // reset during a stall at pc=0x40
    add(0, 3, 0, 32'h40, 0, 32'h40, DS ? imem_word(0) : 32'h0, DS ? 32'h4 : 32'h0, DS);
    add(0, 0, 0, 0, 1, 32'h40, DS ? imem_word(0) : 32'h0, DS ? 32'h4 : 32'h0, DS);
    add(1, 1, 32'h500, 0, 1, 32'h0, 32'h0, 32'h0, 0);
    add(0, 0, 0, 0, 0, 32'h4, imem_word(0), 32'h4, 1);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].src, vecs[i].bt, vecs[i].jt, vecs[i].stall);
      check_all(i, vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pp4, vecs[i].e_valid);
    end

    // Randomized phase against the reference model, starting from a reset.
    m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0;
    for (int c = 0; c < 400; c++) begin
      bit rst, stall;
      logic [1:0] src;
      logic [31:0] bt, jt;
      rst   = (c == 0) || ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 4) == 0);
      src   = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      bt    = $urandom();
      jt    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom();
      apply(rst, src, bt, jt, stall);
      model_step(rst, src, bt, jt, stall);
      check_all(1000 + c, m_pc[31:0], m_instr[31:0], m_pp4[31:0], m_valid);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
